// File: rtl/host_descriptor_merge.sv
// Merges the TS and NTS descriptor streams into one output stream.
// Each class has its own small FIFO; TS has strict priority, bounded by an NTS anti-starvation counter.

module host_descriptor_fifo #(
  parameter int DESC_W     = 46,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [DESC_W-1:0]             wr_data,
  input  logic                          wr_req,
  output logic                          wr_ack,
  input  logic                          pop,
  output logic [DESC_W-1:0]             head,
  output logic [$clog2(FIFO_DEPTH):0]   usedw,
  output logic                          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DESC_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              accept;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
  assign full   = (usedw == (AW+1)'(FIFO_DEPTH));
  assign empty  = (usedw == '0);
  assign accept = wr_req && !full && !wr_ack;
  assign head   = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= accept;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   usedw <= usedw + 1'b1;
        2'b01:   usedw <= usedw - 1'b1;
        default: usedw <= usedw;
      endcase
    end
  end

endmodule

module host_descriptor_merge #(
  parameter int DESC_W       = 46,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [DESC_W-1:0]             iv_ts_descriptor,
  input  logic                          i_ts_descriptor_wr,
  output logic                          o_ts_descriptor_ack,
  input  logic [DESC_W-1:0]             iv_nts_descriptor,
  input  logic                          i_nts_descriptor_wr,
  output logic                          o_nts_descriptor_ack,
  output logic [DESC_W-1:0]             ov_descriptor,
  output logic                          o_descriptor_type,
  output logic                          o_descriptor_wr,
  input  logic                          i_descriptor_ack,
  output logic [$clog2(FIFO_DEPTH):0]   ov_ts_fifo_usedw,
  output logic [$clog2(FIFO_DEPTH):0]   ov_nts_fifo_usedw,
  output logic [1:0]                    merge_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1
  } merge_state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  merge_state_t      state;
  merge_state_t      state_next;
  logic              grant_ts;
  logic              grant_nts;
  logic [3:0]        starve_cnt;
  logic [DESC_W-1:0] ts_head;
  logic [DESC_W-1:0] nts_head;
  logic              ts_empty;
  logic              nts_empty;

  host_descriptor_fifo #(.DESC_W(DESC_W), .FIFO_DEPTH(FIFO_DEPTH)) u_ts_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .wr_data (iv_ts_descriptor),
    .wr_req  (i_ts_descriptor_wr),
    .wr_ack  (o_ts_descriptor_ack),
    .pop     (grant_ts),
    .head    (ts_head),
    .usedw   (ov_ts_fifo_usedw),
    .empty   (ts_empty)
  );

  host_descriptor_fifo #(.DESC_W(DESC_W), .FIFO_DEPTH(FIFO_DEPTH)) u_nts_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .wr_data (iv_nts_descriptor),
    .wr_req  (i_nts_descriptor_wr),
    .wr_ack  (o_nts_descriptor_ack),
    .pop     (grant_nts),
    .head    (nts_head),
    .usedw   (ov_nts_fifo_usedw),
    .empty   (nts_empty)
  );

  assign merge_state = state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // TS wins unless NTS has waited through STARVE_LIMIT consecutive TS grants.
  always_comb begin
    grant_ts   = 1'b0;
    grant_nts  = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (!ts_empty && ((starve_cnt < STARVE_MAX) || nts_empty)) begin
          grant_ts   = 1'b1;
          state_next = WAIT_ACK;
        end else if (!nts_empty) begin
          grant_nts  = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (i_descriptor_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ov_descriptor     <= '0;
      o_descriptor_type <= 1'b0;
      o_descriptor_wr   <= 1'b0;
    end else if (grant_ts) begin
      ov_descriptor     <= ts_head;
      o_descriptor_type <= 1'b1;
      o_descriptor_wr   <= 1'b1;
    end else if (grant_nts) begin
      ov_descriptor     <= nts_head;
      o_descriptor_type <= 1'b0;
      o_descriptor_wr   <= 1'b1;
    end else if (state == WAIT_ACK && i_descriptor_ack) begin
      o_descriptor_wr   <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if (nts_empty || grant_nts) begin
      starve_cnt <= '0;
    end else if (grant_ts && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: doc/host_descriptor_merge.md
# host_descriptor_merge

Merges the time-sensitive (TS) and non-time-sensitive (NTS) descriptor streams from `host_receive_process` into one descriptor stream for the forwarding/queue-management stage. Each class is buffered in its own 4-entry FIFO, so the receive path is never stalled by a single slow grant. Arbitration is strict priority to TS, with an anti-starvation guard for NTS. The block sits directly downstream of `host_receive_process` and replaces its two separate descriptor consumers with one.

## Interface
Parameters:
- `DESC_W`, 46: descriptor width.
- `FIFO_DEPTH`, 4: entries per class FIFO (power of two).
- `STARVE_LIMIT`, 8: consecutive TS grants allowed while NTS is pending.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `iv_ts_descriptor`  in  46  TS descriptor from host receive.
- `i_ts_descriptor_wr`  in  1  TS descriptor valid; source holds it with data until ack.
- `o_ts_descriptor_ack`  out  1  one-cycle accept pulse for TS.
- `iv_nts_descriptor`  in  46  NTS descriptor.
- `i_nts_descriptor_wr`  in  1  NTS descriptor valid; held until ack.
- `o_nts_descriptor_ack`  out  1  one-cycle accept pulse for NTS.
- `ov_descriptor`  out  46  merged descriptor.
- `o_descriptor_type`  out  1  1 = TS, 0 = NTS.
- `o_descriptor_wr`  out  1  merged valid; held until ack.
- `i_descriptor_ack`  in  1  downstream accept.
- `ov_ts_fifo_usedw`  out  3  TS FIFO occupancy, 0..4.
- `ov_nts_fifo_usedw`  out  3  NTS FIFO occupancy, 0..4.
- `merge_state`  out  2  FSM state for debug.

## Operation
**Ingress (identical per class)**
- Accept condition at a clock edge: wr = 1, FIFO not full, and own ack = 0.
- On accept: write the descriptor and drive ack = 1 for exactly one cycle.
- Because ack is high on the following cycle, the same held request is never accepted twice.
- Maximum ingress rate: 1 descriptor per 2 cycles per class.
- FIFO full: ack is withheld and the source keeps holding. Nothing is dropped.
- "Full" is the registered occupancy = `FIFO_DEPTH`. A pop in the same cycle does not permit a write.
- A write and a pop from a non-full FIFO in the same cycle are both performed; occupancy is unchanged.

**Arbiter FSM** (`merge_state`: IDLE = 0, WAIT_ACK = 1)
- In IDLE, the grant rules are evaluated in order:
  - TS FIFO non-empty and (starve_cnt < `STARVE_LIMIT` or NTS FIFO empty): grant TS.
  - Otherwise, NTS FIFO non-empty: grant NTS.
  - Otherwise: stay in IDLE.
- On a grant:
  - Pop the granted FIFO head into `ov_descriptor`.
  - Set `o_descriptor_type` to the granted class.
  - Set `o_descriptor_wr` = 1.
  - Go to WAIT_ACK.
- In WAIT_ACK: `ov_descriptor` and `o_descriptor_type` are stable. On `i_descriptor_ack` = 1, clear `o_descriptor_wr` and return to IDLE.
- `i_descriptor_ack` is ignored in IDLE.

**starve_cnt** (4 bits)
- TS grant while the NTS FIFO is non-empty: increment, saturating at `STARVE_LIMIT`.
- NTS grant: clear.
- NTS FIFO empty: clear.

## Timing
- All outputs reset to 0: acks, wr, type, descriptor, usedw. FSM resets to IDLE, starve_cnt to 0, FIFOs to empty.
- Reset mid-operation: all stored and in-flight descriptors are discarded; no ack is generated.
- Ingress accept at edge t: ack is high during cycle t..t+1 and `usedw` reflects the write after edge t.
- Grant latency: with an empty FIFO and FSM in IDLE, accept at edge t gives `o_descriptor_wr` = 1 after edge t+1.
- Ack at edge t in WAIT_ACK: `o_descriptor_wr` = 0 after edge t. The next grant can come at edge t+1, so sustained output is 1 descriptor per 2 cycles.
- Merged output order within a class is FIFO order. Order between classes follows the arbiter only.

## Test plan
- **Single NTS:** NTS wr with descriptor 0x1234 and downstream ack tied to 1.
  - Required: nts_ack is a 1-cycle pulse.
  - Required: `o_descriptor_wr` goes high 1 cycle after the accept edge, with type 0 and data 0x1234.
  - Required: `ov_nts_fifo_usedw` returns to 0.
- **Simultaneous ingress:** TS and NTS wr asserted in the same cycle.
  - Required: both acked in that cycle.
  - Required: TS is output first (type 1), then NTS.
- **Backpressure:** downstream ack held at 0 while 6 TS descriptors are offered.
  - Required: ack for 5 of them (1 in the output register + 4 in the FIFO), `ov_ts_fifo_usedw` = 4, 6th wr held without ack.
  - After ack is released: all 6 appear in order, with no loss and no duplicates.
- **Anti-starvation:** NTS FIFO holds 1 entry while the TS FIFO is kept continuously fed.
  - Required: exactly 8 TS grants, then 1 NTS grant, then TS resumes.
- **Reset during WAIT_ACK:** assert `i_rst` with both FIFOs non-empty.
  - Required: all outputs are 0 immediately (asynchronous), usedw = 0, FSM = IDLE.
  - Required: no output after release until new ingress arrives.
- **Stray ack:** `i_descriptor_ack` pulsed while in IDLE with empty FIFOs.
  - Required: no state change and `o_descriptor_wr` stays 0.
